// File: rtl/cpsr_flag_update_pkg.sv
// Shared CPSR definitions: flag bit indices, mode encodings, reset value,
// MSR f-field write mask and the staged ALU result record.
// Optional feature macro: CPSR_Q_EN (sticky saturation flag in bit 27).
package cpsr_flag_update_pkg;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;
  localparam int CPSR_Q = 27;

  localparam logic [4:0] MODE_USR = 5'h10;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [4:0] MODE_SYS = 5'h1F;

  localparam logic [31:0] RESET_CPSR_VAL = 32'h0000_00D3;

  // Writable bits of cpsr[31:24]; bits 26:24 always read 0, bit 27 only with Q.
`ifdef CPSR_Q_EN
  localparam logic [7:0] F_WMASK = 8'hF8;
`else
  localparam logic [7:0] F_WMASK = 8'hF0;
`endif

  typedef struct packed {
    logic [31:0] value;
    logic        logical;
    logic        carry;
    logic        shift_carry;
    logic        overflow;
  } alu_res_t;

endpackage

// File: rtl/cpsr_flag_update_calc.sv
// cpsr_flag_calc: combinational NZCV from a staged ALU result.
// Logical ops take C from the shifter and keep the current V.
module cpsr_flag_calc
  import cpsr_flag_update_pkg::*;
(
  input  alu_res_t   i_res,
  input  logic       i_v_in,
  output logic [3:0] o_nzcv
);

  logic w_n, w_z, w_c, w_v;

  assign w_n    = i_res.value[31];
  assign w_z    = ~|i_res.value;
  assign w_c    = i_res.logical ? i_res.shift_carry : i_res.carry;
  assign w_v    = i_res.logical ? i_v_in : i_res.overflow;
  assign o_nzcv = {w_n, w_z, w_c, w_v};

endmodule

// File: rtl/cpsr_flag_update.sv
// cpsr_flag_update: architectural CPSR owner. Flag-setting results are staged
// one cycle then committed (latency 2 to cpsr); MSR writes land in one cycle
// and win over a same-edge commit on the f field. Tracks in-flight flag
// setters so issue can stall on flags_pending.
// Optional feature macro: CPSR_Q_EN (sticky Q flag set by saturating results).
module cpsr_flag_update
  import cpsr_flag_update_pkg::*;
#(
  parameter int          PEND_W     = 3,
  parameter logic [31:0] RESET_CPSR = RESET_CPSR_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_set,
  input  logic        res_valid,
  input  logic        res_s,
  input  logic        res_cond_ok,
  input  logic        res_logical,
  input  logic [31:0] res_value,
  input  logic        res_carry,
  input  logic        res_shift_carry,
  input  logic        res_overflow,
  input  logic        res_sat,
  input  logic        msr_valid,
  input  logic [3:0]  msr_mask,
  input  logic [31:0] msr_data,
  output logic [31:0] cpsr,
  output logic        flags_wr,
  output logic        flags_pending,
  output logic        pend_err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic              r_s1_valid;
  alu_res_t          r_s1_res;
  logic [PEND_W-1:0] r_cnt;
  logic              r_err;
  logic [31:0]       r_cpsr;
  logic [31:0]       w_cpsr_nxt;
  logic [3:0]        w_nzcv;
  logic              w_inc, w_dec;
  logic              w_unused;

`ifdef CPSR_Q_EN
  logic              r_s1_qset;

  // Q set request rides alongside the flag stage; S bit not required.
  always_ff @(posedge clk) begin
    if (reset) r_s1_qset <= 1'b0;
    else       r_s1_qset <= res_valid & res_cond_ok & res_sat;
  end

  assign w_unused = ^{msr_mask[2:1], msr_data[23:8]};
`else
  assign w_unused = ^{msr_mask[2:1], msr_data[23:8], res_sat};
`endif

  // Stage 1: capture result; only S=1, condition-passed results commit.
  always_ff @(posedge clk) begin
    if (reset) r_s1_valid <= 1'b0;
    else       r_s1_valid <= res_valid & res_s & res_cond_ok;
    r_s1_res <= '{value:       res_value,
                  logical:     res_logical,
                  carry:       res_carry,
                  shift_carry: res_shift_carry,
                  overflow:    res_overflow};
  end

  cpsr_flag_calc u_calc (
    .i_res  (r_s1_res),
    .i_v_in (r_cpsr[CPSR_V]),
    .o_nzcv (w_nzcv)
  );

  // Next CPSR: stage-2 commit first, MSR overlays last so it wins on [31:24].
  always_comb begin
    w_cpsr_nxt = r_cpsr;
    if (r_s1_valid) w_cpsr_nxt[CPSR_N:CPSR_V] = w_nzcv;
`ifdef CPSR_Q_EN
    if (r_s1_qset) w_cpsr_nxt[CPSR_Q] = 1'b1;
`endif
    if (msr_valid && msr_mask[3]) w_cpsr_nxt[31:24] = msr_data[31:24] & F_WMASK;
    if (msr_valid && msr_mask[0]) w_cpsr_nxt[7:0]   = msr_data[7:0];
  end

  // CPSR register.
  always_ff @(posedge clk) begin
    if (reset) r_cpsr <= RESET_CPSR;
    else       r_cpsr <= w_cpsr_nxt;
  end

  assign w_inc = issue_set;
  assign w_dec = res_valid & res_s;

  // In-flight counter: saturates at both ends and flags the event stickily.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_inc && !w_dec) begin
      if (r_cnt == CNT_MAX) r_err <= 1'b1;
      else                  r_cnt <= r_cnt + 1'b1;
    end else if (w_dec && !w_inc) begin
      if (r_cnt == '0) r_err <= 1'b1;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cpsr          = r_cpsr;
  assign flags_wr      = r_s1_valid;
  assign flags_pending = (r_cnt != '0) || r_s1_valid;
  assign pend_err      = r_err;

endmodule

// File: tb/tb_cpsr_flag_update.sv
// Scoreboard bench for cpsr_flag_update: the driver computes each cycle's
// expected outputs from a behavioural model and queues them; a monitor on the
// falling edge pops and compares against the DUT.
module tb_cpsr_flag_update;

  localparam int CMAX = 7;

  logic        clk = 1'b0;
  logic        reset, issue_set, res_valid, res_s, res_cond_ok, res_logical;
  logic [31:0] res_value;
  logic        res_carry, res_shift_carry, res_overflow, res_sat, msr_valid;
  logic [3:0]  msr_mask;
  logic [31:0] msr_data;
  logic [31:0] cpsr;
  logic        flags_wr, flags_pending, pend_err;

  always #5 clk = ~clk;

  cpsr_flag_update dut (
    .clk(clk), .reset(reset), .issue_set(issue_set), .res_valid(res_valid),
    .res_s(res_s), .res_cond_ok(res_cond_ok), .res_logical(res_logical),
    .res_value(res_value), .res_carry(res_carry), .res_shift_carry(res_shift_carry),
    .res_overflow(res_overflow), .res_sat(res_sat), .msr_valid(msr_valid),
    .msr_mask(msr_mask), .msr_data(msr_data), .cpsr(cpsr), .flags_wr(flags_wr),
    .flags_pending(flags_pending), .pend_err(pend_err)
  );

  typedef struct packed {
    logic rst, iss, rv, rs, rok, rlog;
    logic [31:0] val;
    logic c, sc, o, sat, mv;
    logic [3:0] mm;
    logic [31:0] md;
  } stim_t;

  typedef struct {
    bit          chk;
    logic [31:0] cpsr;
    logic        fw, fp, err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Model state: architectural view, not the RTL structure.
  bit          m_init = 0;
  logic [31:0] m_cpsr;
  int          m_cnt;
  bit          m_err;
  bit          st_v, st_q;
  stim_t       st;

  task automatic drive(input stim_t s);
    exp_t        e;
    logic [31:0] nc;
    bit          ret;
    @(posedge clk); #1;
    reset = s.rst; issue_set = s.iss; res_valid = s.rv; res_s = s.rs;
    res_cond_ok = s.rok; res_logical = s.rlog; res_value = s.val;
    res_carry = s.c; res_shift_carry = s.sc; res_overflow = s.o; res_sat = s.sat;
    msr_valid = s.mv; msr_mask = s.mm; msr_data = s.md;
    e.chk = m_init; e.cpsr = m_cpsr; e.fw = st_v;
    e.fp = (m_cnt != 0) || st_v; e.err = m_err;
    q.push_back(e);
    if (s.rst) begin
      m_cpsr = 32'h0000_00D3; m_cnt = 0; m_err = 0; st_v = 0; st_q = 0; m_init = 1;
    end else begin
      nc = m_cpsr;
      if (st_v) begin
        nc[31] = st.val[31];
        nc[30] = (st.val == 32'd0);
        nc[29] = st.rlog ? st.sc : st.c;
        nc[28] = st.rlog ? m_cpsr[28] : st.o;
      end
      if (st_q) nc[27] = 1'b1;
      if (s.mv && s.mm[3]) begin
        nc[31:28] = s.md[31:28];
`ifdef CPSR_Q_EN
        nc[27] = s.md[27];
`else
        nc[27] = 1'b0;
`endif
        nc[26:24] = 3'b000;
      end
      if (s.mv && s.mm[0]) nc[7:0] = s.md[7:0];
      m_cpsr = nc;
      ret = s.rv && s.rs;
      if (s.iss && !ret) begin
        if (m_cnt == CMAX) m_err = 1; else m_cnt++;
      end else if (!s.iss && ret) begin
        if (m_cnt == 0) m_err = 1; else m_cnt--;
      end
      st_v = s.rv && s.rs && s.rok;
`ifdef CPSR_Q_EN
      st_q = s.rv && s.rok && s.sat;
`else
      st_q = 0;
`endif
      st = s;
    end
  endtask

  task automatic t_idle(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin s = '0; drive(s); end
  endtask

  task automatic t_reset();
    stim_t s;
    s = '0; s.rst = 1; drive(s);
  endtask

  task automatic t_issue();
    stim_t s;
    s = '0; s.iss = 1; drive(s);
  endtask

  task automatic t_res(input bit rs, input bit ok, input bit lg, input logic [31:0] v,
                       input bit c, input bit sc, input bit o, input bit sat);
    stim_t s;
    s = '0; s.rv = 1; s.rs = rs; s.rok = ok; s.rlog = lg; s.val = v;
    s.c = c; s.sc = sc; s.o = o; s.sat = sat;
    drive(s);
  endtask

  task automatic t_msr(input logic [3:0] m, input logic [31:0] d);
    stim_t s;
    s = '0; s.mv = 1; s.mm = m; s.md = d; drive(s);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        chk("cpsr", cpsr, e.cpsr);
        chk("flags_wr", {31'd0, flags_wr}, {31'd0, e.fw});
        chk("flags_pending", {31'd0, flags_pending}, {31'd0, e.fp});
        chk("pend_err", {31'd0, pend_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    reset = 1; issue_set = 0; res_valid = 0; res_s = 0; res_cond_ok = 0;
    res_logical = 0; res_value = 0; res_carry = 0; res_shift_carry = 0;
    res_overflow = 0; res_sat = 0; msr_valid = 0; msr_mask = 0; msr_data = 0;
    m_cpsr = 0; m_cnt = 0; m_err = 0; st_v = 0; st_q = 0; st = '0;

    t_reset(); t_reset(); t_idle(2);
    // Zero result -> Z
    t_issue(); t_res(1, 1, 0, 32'h0, 0, 0, 0, 0); t_idle(3);
    // Arithmetic then logical (V kept)
    t_issue(); t_res(1, 1, 0, 32'h8000_0000, 1, 0, 1, 0); t_idle(1);
    t_issue(); t_res(1, 1, 1, 32'h1, 1, 0, 0, 0); t_idle(3);
    // Condition failed
    t_issue(); t_res(1, 0, 0, 32'h0, 1, 1, 1, 0); t_idle(3);
    // Counter overflow at max
    for (int i = 0; i < 8; i++) t_issue();
    t_idle(2); t_reset(); t_idle(1);
    // Retire at zero
    t_res(1, 0, 0, 32'h5, 0, 0, 0, 0); t_idle(2); t_reset(); t_idle(1);
    // MSR f-field wins over same-edge commit
    t_issue(); t_res(1, 1, 0, 32'h8000_0000, 0, 0, 0, 0);
    t_msr(4'b1000, 32'h5000_0000); t_idle(2);
    // MSR c-field plus commit both land
    t_issue(); t_res(1, 1, 0, 32'h0, 1, 0, 0, 0);
    t_msr(4'b0001, 32'h0000_001F); t_idle(2);
    // Q: saturating result with S=0, later results, MSR f clears
    t_res(0, 1, 0, 32'h7FFF_FFFF, 0, 0, 0, 1); t_idle(2);
    t_issue(); t_res(1, 1, 0, 32'h1, 0, 0, 0, 0); t_idle(2);
    t_msr(4'b1000, 32'hF000_0000); t_idle(2);
    // Back-to-back commits
    t_issue(); t_issue(); t_issue();
    t_res(1, 1, 0, 32'h0, 1, 0, 1, 0);
    t_res(1, 1, 0, 32'h8000_0001, 0, 0, 0, 0);
    t_res(1, 1, 1, 32'h4, 0, 1, 0, 0);
    t_idle(3);
    // Reset mid-flight drops staged commit
    t_issue(); t_res(1, 1, 0, 32'h8000_0000, 1, 1, 1, 0); t_reset(); t_idle(3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst  = ($urandom_range(0, 149) == 0);
      s.iss  = ($urandom_range(0, 2) == 0);
      s.rv   = ($urandom_range(0, 2) == 0);
      s.rs   = $urandom_range(0, 1);
      s.rok  = ($urandom_range(0, 3) != 0);
      s.rlog = $urandom_range(0, 1);
      s.val  = $urandom;
      if ($urandom_range(0, 5) == 0) s.val = 32'h0;
      if ($urandom_range(0, 7) == 0) s.val = 32'h8000_0000;
      s.c    = $urandom_range(0, 1);
      s.sc   = $urandom_range(0, 1);
      s.o    = $urandom_range(0, 1);
      s.sat  = ($urandom_range(0, 7) == 0);
      s.mv   = ($urandom_range(0, 9) == 0);
      s.mm   = 4'($urandom_range(0, 15));
      s.md   = $urandom;
      drive(s);
    end
    t_idle(3);
    @(posedge clk); @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
